// File: rtl/axi_xbar_pkg.sv
// Shared types and constants for the 1-master / 2-slave AXI4-Lite crossbar.
// Holds the target enum, response codes, FSM state types and default region map.
package axi_xbar_pkg;

    typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_ERR} xbar_tgt_t;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_S0_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_S0_SIZE = 32'h0800_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'ha000_0000;
    localparam logic [31:0] DEF_S1_SIZE = 32'h0000_1000;

    // Wrapping subtraction gives an exclusive upper bound without a 33-bit adder.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/axi_xbar_if.sv
// AXI4-Lite bundle (32-bit address/data) with master and slave modports.
interface axi_if;
    import axi_xbar_pkg::*;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    axi_resp_t   bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    axi_resp_t   rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_xbar_decode.sv
// Combinational address-to-target decoder; s1 wins on overlap.
// Unmapped addresses yield TGT_ERR only when AXI_XBAR_DECERR_EN is defined, else TGT_S0.
module axi_xbar_decode
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S0_SIZE = DEF_S0_SIZE,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S1_SIZE = DEF_S1_SIZE
) (
    input  logic [31:0] addr,
    output xbar_tgt_t   tgt
);

    always_comb begin
        if (in_region(addr, S1_BASE, S1_SIZE)) begin
            tgt = TGT_S1;
        end else if (in_region(addr, S0_BASE, S0_SIZE)) begin
            tgt = TGT_S0;
        end else begin
`ifdef AXI_XBAR_DECERR_EN
            tgt = TGT_ERR;
`else
            tgt = TGT_S0;
`endif
        end
    end

endmodule

// File: rtl/axi_xbar.sv
// AXI4-Lite 1x2 crossbar: independent read and write FSMs, combinational data paths.
// Define AXI_XBAR_DECERR_EN to answer unmapped addresses internally with DECERR.
module axi_xbar
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S0_SIZE = DEF_S0_SIZE,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S1_SIZE = DEF_S1_SIZE
) (
    input  logic  clk,
    input  logic  reset,
    axi_if.slave  m,
    axi_if.master s0,
    axi_if.master s1
);

    rd_state_t rd_state_reg;
    xbar_tgt_t rd_tgt_reg;
    wr_state_t wr_state_reg;
    xbar_tgt_t wr_tgt_reg;
    logic      w_done_reg;

    xbar_tgt_t ar_tgt;
    xbar_tgt_t aw_tgt;
    logic      ar_hs, r_hs, aw_hs, w_hs, b_hs;

    axi_xbar_decode #(
        .S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE)
    ) u_ar_dec (
        .addr(m.araddr),
        .tgt (ar_tgt)
    );

    axi_xbar_decode #(
        .S0_BASE(S0_BASE), .S0_SIZE(S0_SIZE), .S1_BASE(S1_BASE), .S1_SIZE(S1_SIZE)
    ) u_aw_dec (
        .addr(m.awaddr),
        .tgt (aw_tgt)
    );

    assign ar_hs = m.arvalid && m.arready;
    assign r_hs  = m.rvalid  && m.rready;
    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid  && m.wready;
    assign b_hs  = m.bvalid  && m.bready;

    assign s0.araddr = m.araddr;
    assign s1.araddr = m.araddr;
    assign s0.awaddr = m.awaddr;
    assign s1.awaddr = m.awaddr;
    assign s0.wdata  = m.wdata;
    assign s1.wdata  = m.wdata;
    assign s0.wstrb  = m.wstrb;
    assign s1.wstrb  = m.wstrb;

    // Read channel steering; everything handshake-related is forced low during reset.
    always_comb begin
        s0.arvalid = 1'b0;
        s1.arvalid = 1'b0;
        s0.rready  = 1'b0;
        s1.rready  = 1'b0;
        m.arready  = 1'b0;
        m.rvalid   = 1'b0;
        m.rdata    = 32'h0;
        m.rresp    = RESP_OKAY;
        if (!reset) begin
            case (rd_state_reg)
                RD_IDLE: begin
                    case (ar_tgt)
                        TGT_S0: begin
                            s0.arvalid = m.arvalid;
                            m.arready  = s0.arready;
                        end
                        TGT_S1: begin
                            s1.arvalid = m.arvalid;
                            m.arready  = s1.arready;
                        end
`ifdef AXI_XBAR_DECERR_EN
                        TGT_ERR: m.arready = 1'b1;
`endif
                        default: ;
                    endcase
                end
                RD_RESP: begin
                    case (rd_tgt_reg)
                        TGT_S0: begin
                            m.rvalid  = s0.rvalid;
                            m.rdata   = s0.rdata;
                            m.rresp   = s0.rresp;
                            s0.rready = m.rready;
                        end
                        TGT_S1: begin
                            m.rvalid  = s1.rvalid;
                            m.rdata   = s1.rdata;
                            m.rresp   = s1.rresp;
                            s1.rready = m.rready;
                        end
`ifdef AXI_XBAR_DECERR_EN
                        TGT_ERR: begin
                            m.rvalid = 1'b1;
                            m.rresp  = RESP_DECERR;
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_reg <= RD_IDLE;
            rd_tgt_reg   <= TGT_S0;
        end else begin
            case (rd_state_reg)
                RD_IDLE: if (ar_hs) begin
                    rd_tgt_reg   <= ar_tgt;
                    rd_state_reg <= RD_RESP;
                end
                RD_RESP: if (r_hs) rd_state_reg <= RD_IDLE;
                default: rd_state_reg <= RD_IDLE;
            endcase
        end
    end

    // Write channel steering. W is held off until AW is presented; w_done_reg
    // remembers a W that a slave accepted before its AW.
    always_comb begin
        s0.awvalid = 1'b0;
        s1.awvalid = 1'b0;
        s0.wvalid  = 1'b0;
        s1.wvalid  = 1'b0;
        s0.bready  = 1'b0;
        s1.bready  = 1'b0;
        m.awready  = 1'b0;
        m.wready   = 1'b0;
        m.bvalid   = 1'b0;
        m.bresp    = RESP_OKAY;
        if (!reset) begin
            case (wr_state_reg)
                WR_IDLE: begin
                    case (aw_tgt)
                        TGT_S0: begin
                            s0.awvalid = m.awvalid;
                            m.awready  = s0.awready;
                            s0.wvalid  = m.wvalid && m.awvalid && !w_done_reg;
                            m.wready   = s0.wready && m.awvalid && !w_done_reg;
                        end
                        TGT_S1: begin
                            s1.awvalid = m.awvalid;
                            m.awready  = s1.awready;
                            s1.wvalid  = m.wvalid && m.awvalid && !w_done_reg;
                            m.wready   = s1.wready && m.awvalid && !w_done_reg;
                        end
`ifdef AXI_XBAR_DECERR_EN
                        TGT_ERR: begin
                            m.awready = 1'b1;
                            m.wready  = m.awvalid && !w_done_reg;
                        end
`endif
                        default: ;
                    endcase
                end
                WR_DATA: begin
                    case (wr_tgt_reg)
                        TGT_S0: begin
                            s0.wvalid = m.wvalid;
                            m.wready  = s0.wready;
                        end
                        TGT_S1: begin
                            s1.wvalid = m.wvalid;
                            m.wready  = s1.wready;
                        end
`ifdef AXI_XBAR_DECERR_EN
                        TGT_ERR: m.wready = 1'b1;
`endif
                        default: ;
                    endcase
                end
                WR_RESP: begin
                    case (wr_tgt_reg)
                        TGT_S0: begin
                            m.bvalid  = s0.bvalid;
                            m.bresp   = s0.bresp;
                            s0.bready = m.bready;
                        end
                        TGT_S1: begin
                            m.bvalid  = s1.bvalid;
                            m.bresp   = s1.bresp;
                            s1.bready = m.bready;
                        end
`ifdef AXI_XBAR_DECERR_EN
                        TGT_ERR: begin
                            m.bvalid = 1'b1;
                            m.bresp  = RESP_DECERR;
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_reg <= WR_IDLE;
            wr_tgt_reg   <= TGT_S0;
            w_done_reg   <= 1'b0;
        end else begin
            case (wr_state_reg)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_tgt_reg   <= aw_tgt;
                        w_done_reg   <= 1'b0;
                        wr_state_reg <= (w_hs || w_done_reg) ? WR_RESP : WR_DATA;
                    end else if (w_hs) begin
                        w_done_reg <= 1'b1;
                    end
                end
                WR_DATA: if (w_hs) wr_state_reg <= WR_RESP;
                WR_RESP: if (b_hs) wr_state_reg <= WR_IDLE;
                default: wr_state_reg <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_xbar.sv
// Directed self-checking bench for axi_xbar with two behavioural AXI4-Lite slaves.
module tb_axi_xbar;
    import axi_xbar_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic sl_rst;
    logic [31:0] rd_val [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_if m_if ();
    axi_if s_if [2] ();

    axi_xbar dut (
        .clk  (clk),
        .reset(reset),
        .m    (m_if),
        .s0   (s_if[0]),
        .s1   (s_if[1])
    );

    // Slave model: always ready, R returned 3 cycles after AR, B one cycle after AW+W.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sl
        logic [1:0]  r_cnt;
        logic        aw_got, w_got;
        logic        ar_seen, aw_seen, w_seen;
        logic [31:0] aw_addr, w_data;
        logic        aw_hs, w_hs, got_aw, got_w;

        assign s_if[gi].arready = 1'b1;
        assign s_if[gi].awready = 1'b1;
        assign s_if[gi].wready  = 1'b1;
        assign s_if[gi].rresp   = 2'b00;
        assign s_if[gi].bresp   = 2'b00;
        assign aw_hs  = s_if[gi].awvalid && s_if[gi].awready;
        assign w_hs   = s_if[gi].wvalid && s_if[gi].wready;
        assign got_aw = aw_got || aw_hs;
        assign got_w  = w_got || w_hs;

        always @(posedge clk) begin
            if (sl_rst) begin
                s_if[gi].rvalid <= 1'b0;
                s_if[gi].rdata  <= 32'h0;
                s_if[gi].bvalid <= 1'b0;
                r_cnt   <= 2'd0;
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                ar_seen <= 1'b0;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
                aw_addr <= 32'h0;
                w_data  <= 32'h0;
            end else begin
                if (s_if[gi].arvalid) ar_seen <= 1'b1;
                if (s_if[gi].awvalid) aw_seen <= 1'b1;
                if (s_if[gi].wvalid)  w_seen  <= 1'b1;
                if (s_if[gi].rvalid && s_if[gi].rready) s_if[gi].rvalid <= 1'b0;
                if (s_if[gi].arvalid && s_if[gi].arready) begin
                    r_cnt <= 2'd3;
                end else if (r_cnt > 2'd1) begin
                    r_cnt <= r_cnt - 2'd1;
                end else if (r_cnt == 2'd1) begin
                    r_cnt <= 2'd0;
                    s_if[gi].rvalid <= 1'b1;
                    s_if[gi].rdata  <= rd_val[gi];
                end
                if (aw_hs) aw_addr <= s_if[gi].awaddr;
                if (w_hs)  w_data  <= s_if[gi].wdata;
                if (s_if[gi].bvalid && s_if[gi].bready) s_if[gi].bvalid <= 1'b0;
                if (got_aw && got_w) begin
                    s_if[gi].bvalid <= 1'b1;
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                end else begin
                    aw_got <= got_aw;
                    w_got  <= got_w;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic slave_clear();
        sl_rst = 1'b1;
        @(negedge clk);
        sl_rst = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a);
        int n = 0;
        m_if.araddr  = a;
        m_if.arvalid = 1'b1;
        #1;
        while (!m_if.arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_ready", 32'(m_if.arready), 32'd1);
        @(negedge clk);
        m_if.arvalid = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        m_if.rready = 1'b1;
        #1;
        while (!m_if.rvalid && n < 20) begin @(negedge clk); n++; end
        chk("r_valid", 32'(m_if.rvalid), 32'd1);
        d = m_if.rdata;
        r = m_if.rresp;
        @(negedge clk);
    endtask

    task automatic aw_w_send(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        m_if.awaddr  = a;
        m_if.wdata   = d;
        m_if.awvalid = 1'b1;
        m_if.wvalid  = 1'b1;
        #1;
        while (!(m_if.awready && m_if.wready) && n < 20) begin @(negedge clk); n++; end
        chk("aw_w_ready", 32'(m_if.awready && m_if.wready), 32'd1);
        @(negedge clk);
        m_if.awvalid = 1'b0;
        m_if.wvalid  = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] a);
        int n = 0;
        m_if.awaddr  = a;
        m_if.awvalid = 1'b1;
        #1;
        while (!m_if.awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_ready", 32'(m_if.awready), 32'd1);
        @(negedge clk);
        m_if.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d);
        int n = 0;
        m_if.wdata  = d;
        m_if.wvalid = 1'b1;
        #1;
        while (!m_if.wready && n < 20) begin @(negedge clk); n++; end
        chk("w_ready", 32'(m_if.wready), 32'd1);
        @(negedge clk);
        m_if.wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] r);
        int n = 0;
        m_if.bready = 1'b1;
        #1;
        while (!m_if.bvalid && n < 20) begin @(negedge clk); n++; end
        chk("b_valid", 32'(m_if.bvalid), 32'd1);
        r = m_if.bresp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        reset = 1'b1;
        sl_rst = 1'b1;
        rd_val[0] = 32'h0;
        rd_val[1] = 32'h0;
        m_if.araddr  = 32'h8000_0000;
        m_if.arvalid = 1'b1;
        m_if.awaddr  = 32'h8000_0000;
        m_if.awvalid = 1'b1;
        m_if.wdata   = 32'h0;
        m_if.wstrb   = 4'hf;
        m_if.wvalid  = 1'b1;
        m_if.bready  = 1'b1;
        m_if.rready  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset: valids from m must not leak, readies must be low
        chk("rst_s0_arvalid", 32'(s_if[0].arvalid), 32'd0);
        chk("rst_s0_awvalid", 32'(s_if[0].awvalid), 32'd0);
        chk("rst_s0_wvalid",  32'(s_if[0].wvalid),  32'd0);
        chk("rst_m_arready",  32'(m_if.arready),    32'd0);
        chk("rst_m_awready",  32'(m_if.awready),    32'd0);
        chk("rst_m_wready",   32'(m_if.wready),     32'd0);
        chk("rst_m_rvalid",   32'(m_if.rvalid),     32'd0);
        chk("rst_m_bvalid",   32'(m_if.bvalid),     32'd0);
        chk("rst_rd_state",   32'(dut.rd_state_reg), 32'(RD_IDLE));
        chk("rst_wr_state",   32'(dut.wr_state_reg), 32'(WR_IDLE));
        m_if.arvalid = 1'b0;
        m_if.awvalid = 1'b0;
        m_if.wvalid  = 1'b0;
        reset  = 1'b0;
        sl_rst = 1'b0;
        @(negedge clk);

        // Read from s0 with 3-cycle slave latency
        rd_val[0] = 32'hdead_beef;
        ar_send(32'h8000_0010);
        chk("rd_in_resp", 32'(dut.rd_state_reg), 32'(RD_RESP));
        r_recv(d, r);
        chk("rd_s0_data", d, 32'hdead_beef);
        chk("rd_s0_resp", 32'(r), 32'(RESP_OKAY));
        chk("rd_back_idle", 32'(dut.rd_state_reg), 32'(RD_IDLE));
        chk("rd_s0_seen", 32'(g_sl[0].ar_seen), 32'd1);
        chk("rd_s1_quiet", 32'(g_sl[1].ar_seen), 32'd0);
        slave_clear();

        // Write to s1 with AW and W together: IDLE -> RESP directly
        chk("wr_idle", 32'(dut.wr_state_reg), 32'(WR_IDLE));
        aw_w_send(32'ha000_03f8, 32'h0000_0041);
        chk("wr_direct_resp", 32'(dut.wr_state_reg), 32'(WR_RESP));
        b_recv(r);
        chk("wr_s1_bresp", 32'(r), 32'(RESP_OKAY));
        chk("wr_s1_awaddr", g_sl[1].aw_addr, 32'ha000_03f8);
        chk("wr_s1_wdata", g_sl[1].w_data, 32'h0000_0041);
        chk("wr_s0_quiet", 32'(g_sl[0].aw_seen), 32'd0);
        chk("wr_back_idle", 32'(dut.wr_state_reg), 32'(WR_IDLE));
        slave_clear();

        // AW first, W two cycles later
        aw_send(32'h8000_0000);
        for (int i = 0; i < 2; i++) begin
            chk("wd_state", 32'(dut.wr_state_reg), 32'(WR_DATA));
            chk("wd_awready", 32'(m_if.awready), 32'd0);
            @(negedge clk);
        end
        w_send(32'h1234_5678);
        chk("wd_to_resp", 32'(dut.wr_state_reg), 32'(WR_RESP));
        b_recv(r);
        chk("wd_bresp", 32'(r), 32'(RESP_OKAY));
        chk("wd_s0_awaddr", g_sl[0].aw_addr, 32'h8000_0000);
        chk("wd_s0_wdata", g_sl[0].w_data, 32'h1234_5678);
        chk("wd_s1_quiet", 32'(g_sl[1].aw_seen), 32'd0);
        slave_clear();

        // Last word of s1 region still routes to s1
        rd_val[1] = 32'h0bad_cafe;
        ar_send(32'ha000_0ffc);
        r_recv(d, r);
        chk("bnd_s1_top", d, 32'h0bad_cafe);
        chk("bnd_s0_quiet", 32'(g_sl[0].ar_seen), 32'd0);
        slave_clear();

`ifdef AXI_XBAR_DECERR_EN
        // Unmapped accesses answered internally with DECERR
        ar_send(32'h0000_1000);
        r_recv(d, r);
        chk("err_rdata", d, 32'h0);
        chk("err_rresp", 32'(r), 32'(RESP_DECERR));
        aw_w_send(32'h8800_0000, 32'h0000_0077);
        b_recv(r);
        chk("err_bresp", 32'(r), 32'(RESP_DECERR));
        ar_send(32'ha000_1000);
        r_recv(d, r);
        chk("err_s1_end_rresp", 32'(r), 32'(RESP_DECERR));
        chk("err_no_ar", 32'(g_sl[0].ar_seen || g_sl[1].ar_seen), 32'd0);
        chk("err_no_aw", 32'(g_sl[0].aw_seen || g_sl[1].aw_seen), 32'd0);
        chk("err_no_w",  32'(g_sl[0].w_seen  || g_sl[1].w_seen),  32'd0);
        slave_clear();
`else
        // Unmapped accesses fall through to s0
        rd_val[0] = 32'h0000_5a5a;
        ar_send(32'h0000_1000);
        r_recv(d, r);
        chk("fold_rdata", d, 32'h0000_5a5a);
        chk("fold_rresp", 32'(r), 32'(RESP_OKAY));
        slave_clear();
        ar_send(32'ha000_1000);
        r_recv(d, r);
        chk("fold_s1_end_data", d, 32'h0000_5a5a);
        chk("fold_s1_end_quiet", 32'(g_sl[1].ar_seen), 32'd0);
        slave_clear();
        aw_w_send(32'h8800_0000, 32'h0000_0077);
        b_recv(r);
        chk("fold_bresp", 32'(r), 32'(RESP_OKAY));
        chk("fold_awaddr", g_sl[0].aw_addr, 32'h8800_0000);
        chk("fold_s1_aw_quiet", 32'(g_sl[1].aw_seen), 32'd0);
        slave_clear();
`endif

        // Concurrent read of s1 and write to s0; held rready stalls only the read
        rd_val[1] = 32'hc0de_0001;
        m_if.rready  = 1'b0;
        m_if.bready  = 1'b1;
        m_if.araddr  = 32'ha000_0000;
        m_if.arvalid = 1'b1;
        m_if.awaddr  = 32'h8000_0004;
        m_if.wdata   = 32'h0000_0099;
        m_if.awvalid = 1'b1;
        m_if.wvalid  = 1'b1;
        #1;
        chk("cc_arready", 32'(m_if.arready), 32'd1);
        chk("cc_aw_w_ready", 32'(m_if.awready && m_if.wready), 32'd1);
        @(negedge clk);
        m_if.arvalid = 1'b0;
        m_if.awvalid = 1'b0;
        m_if.wvalid  = 1'b0;
        chk("cc_rd_resp", 32'(dut.rd_state_reg), 32'(RD_RESP));
        chk("cc_wr_resp", 32'(dut.wr_state_reg), 32'(WR_RESP));
        chk("cc_bvalid", 32'(m_if.bvalid), 32'd1);
        @(negedge clk);
        chk("cc_wr_done", 32'(dut.wr_state_reg), 32'(WR_IDLE));
        chk("cc_s0_wdata", g_sl[0].w_data, 32'h0000_0099);
        repeat (4) @(negedge clk);
        chk("cc_rvalid_held", 32'(m_if.rvalid), 32'd1);
        chk("cc_rd_stalled", 32'(dut.rd_state_reg), 32'(RD_RESP));
        chk("cc_s1_rready", 32'(s_if[1].rready), 32'd0);
        r_recv(d, r);
        chk("cc_rdata", d, 32'hc0de_0001);
        chk("cc_rd_idle", 32'(dut.rd_state_reg), 32'(RD_IDLE));
        slave_clear();

        // Reset while a response from s0 is pending
        rd_val[0] = 32'h1111_1111;
        m_if.rready = 1'b0;
        ar_send(32'h8000_0020);
        for (int i = 0; i < 20 && !m_if.rvalid; i++) @(negedge clk);
        chk("mr_rvalid_pending", 32'(m_if.rvalid), 32'd1);
        reset = 1'b1;
        m_if.rready = 1'b1;
        @(negedge clk);
        chk("mr_rvalid_in_rst", 32'(m_if.rvalid), 32'd0);
        chk("mr_s0_still_valid", 32'(s_if[0].rvalid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_rd_idle", 32'(dut.rd_state_reg), 32'(RD_IDLE));
        chk("mr_rvalid_after", 32'(m_if.rvalid), 32'd0);
        chk("mr_s0_rready", 32'(s_if[0].rready), 32'd0);
        slave_clear();
        rd_val[0] = 32'h2222_2222;
        ar_send(32'h8000_0030);
        r_recv(d, r);
        chk("mr_new_rdata", d, 32'h2222_2222);
        chk("mr_new_rresp", 32'(r), 32'(RESP_OKAY));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_xbar.md
AXI_XBAR -- requirements
Module: axi_xbar

Interface
REQ-001 The block SHALL have parameter S0_BASE, default 32'h8000_0000, giving the base address of the memory region routed to s0.
REQ-002 The block SHALL have parameter S0_SIZE, default 32'h0800_0000, giving the byte size of the s0 region (power of two).
REQ-003 The block SHALL have parameter S1_BASE, default 32'ha000_0000, giving the base address of the device region routed to s1.
REQ-004 The block SHALL have parameter S1_SIZE, default 32'h0000_1000, giving the byte size of the s1 region (power of two).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port m, axi_if.slave: the upstream AXI4-Lite master, typically the arbiter output.
REQ-008 The block SHALL have port s0, axi_if.master: the memory slave.
REQ-009 The block SHALL have port s1, axi_if.master: the device slave (UART/CLINT).

Function
REQ-010 Address decode SHALL be addr in [S1_BASE, S1_BASE+S1_SIZE) -> S1, else addr in [S0_BASE, S0_BASE+S0_SIZE) -> S0, else ERR; S1 SHALL take priority on overlap; the upper bound SHALL be exclusive.
REQ-011 The read path SHALL use FSM RD_IDLE/RD_RESP plus a registered target rd_tgt (S0, S1, ERR); the write path SHALL use FSM WR_IDLE/WR_DATA/WR_RESP plus a registered target wr_tgt.
REQ-012 In RD_IDLE, m.arvalid SHALL be forwarded only to the decoded slave; m.arready SHALL equal that slave's arready; araddr SHALL be broadcast to both slaves.
REQ-013 On an m AR handshake, the FSM SHALL latch rd_tgt and enter RD_RESP on the next cycle; in RD_RESP, m.arready SHALL be 0 and only slave rd_tgt SHALL see rready.
REQ-014 In RD_RESP, the FSM SHALL return to RD_IDLE on m.rvalid && m.rready; there SHALL be no added latency on the R path (combinational mux from the selected slave).
REQ-015 In WR_IDLE, AW and W SHALL be forwarded to the slave decoded from m.awaddr; m.wready SHALL be 0 while m.awvalid is 0 (no W before AW).
REQ-016 On AW handshake with W handshake in the same cycle, the FSM SHALL go to WR_RESP; on AW handshake alone, it SHALL go to WR_DATA; from WR_DATA, the W handshake SHALL lead to WR_RESP; from WR_RESP, m.bvalid && m.bready SHALL lead to WR_IDLE.
REQ-017 In WR_DATA, m.awready SHALL be 0; in WR_RESP, m.awready and m.wready SHALL be 0; B SHALL be muxed from wr_tgt only.
REQ-018 The read and write paths SHALL be fully independent; a concurrent read to s0 and write to s1 SHALL proceed in parallel.
REQ-019 Unselected slaves SHALL see arvalid, awvalid, wvalid, rready and bready all equal to 0.
REQ-020 rresp and bresp SHALL be 2 bits: OKAY=2'b00, DECERR=2'b11.

Reset
REQ-021 While reset is high, both FSMs SHALL go to IDLE, rd_tgt and wr_tgt SHALL be set to S0, and every valid/ready output SHALL be driven to 0 in the cycle after reset is sampled.
REQ-022 On reset mid-transaction, the outstanding response SHALL be discarded and no stale rvalid/bvalid SHALL reach m after reset is released.

Configuration
REQ-023 With AXI_XBAR_DECERR_EN defined, target ERR SHALL be handled internally: arready/awready/wready SHALL be 1 in IDLE; in RESP, rvalid=1, rdata=0, rresp=DECERR, or bvalid=1, bresp=DECERR; no slave SHALL see the access.
REQ-024 Without AXI_XBAR_DECERR_EN, ERR SHALL be folded into S0 (unmapped addresses routed to s0), and the ERR responder logic SHALL be absent.

Structure
REQ-025 Package axi_xbar_pkg SHALL hold typedef enum xbar_tgt_t {TGT_S0, TGT_S1, TGT_ERR}, the RESP_OKAY/RESP_DECERR constants, and the default region bases/sizes.
REQ-026 Sub-module axi_xbar_decode SHALL be a combinational address-to-xbar_tgt_t decoder, instantiated twice (AR, AW).

Verification
REQ-027 Test: read 32'h8000_0010, with s0 returning rdata 32'hdead_beef after 3 cycles -> m.rdata=32'hdead_beef, rresp=OKAY, and s1.arvalid never asserted.
REQ-028 Test: write 32'ha000_03f8 with data 32'h41, with AW and W in the same cycle -> s1 receives both, FSM goes WR_IDLE->WR_RESP, and bresp=OKAY.
REQ-029 Test: AW to 32'h8000_0000, then W 2 cycles later -> FSM stays in WR_DATA with m.awready=0 until W, then completes through s0.
REQ-030 Test: with AXI_XBAR_DECERR_EN defined, read 32'h0000_1000 and write 32'h8800_0000 (boundary) -> rresp=DECERR, rdata=0, bresp=DECERR, and no slave valid asserted.
REQ-031 Test: concurrent read of s1 with a write to s0 -> both complete independently, and a held m.rready=0 stalls only the read.
REQ-032 Test: reset asserted while in RD_RESP with s0.rvalid pending -> after reset, FSM is in RD_IDLE, m.rvalid=0, and a new read proceeds normally.
